seq_pattern_tx: RTL and testbench

Serial pattern transmitter: accepts a parallel bit pattern, length and repeat count through a start/ready handshake, then drives the pattern onto a single-bit serial line, MSB-first, one bit per clock. Consecutive repeats are separated by an idle gap. It is the stimulus/transmit end for the team's serial sequence detectors, whose `in` port is driven by this block's `out`.

---
 rtl/seq_tx_pkg.sv | 28 ++
 rtl/seq_pattern_tx_if.sv | 29 ++
 rtl/seq_bit_counter.sv | 29 ++
 rtl/seq_pattern_tx.sv | 178 +++++++++++++++++
 tb/tb_seq_pattern_tx.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/seq_tx_pkg.sv
// Shared types and constants for the serial pattern transmitter.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package seq_tx_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        GAP_WAIT = 2'd2,
        DONE     = 2'd3
    } state_t;

    // Width needed to hold a length in the range 0..max_len.
    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    // Width of the gap down-counter; never narrower than one bit.
    function automatic int gap_width(input int gap);
        return (gap < 1) ? 1 : $clog2(gap + 1);
    endfunction

    localparam logic RST_READY     = 1'b1;
    localparam logic RST_OUT       = 1'b0;
    localparam logic RST_OUT_VALID = 1'b0;
    localparam logic RST_DONE      = 1'b0;

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Job request / serial output bundle of the pattern transmitter.
// Latency: n/a (wires only).
// Backpressure: start is only taken while ready is high.
interface seq_pattern_tx_if
    import seq_tx_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int REP_W   = 4,
    parameter int LEN_W   = len_width(MAX_LEN)
);
    logic               start;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   len;
    logic [REP_W-1:0]   reps;
    logic               ready;
    logic               out;
    logic               out_valid;
    logic               done;

    modport master (
        output start, pattern, len, reps,
        input  ready, out, out_valid, done
    );

    modport slave (
        input  start, pattern, len, reps,
        output ready, out, out_valid, done
    );
endinterface

// File: rtl/seq_bit_counter.sv
// Loadable down-counter with a zero flag; saturates at zero.
// Latency: load/decrement visible one cycle after the edge.
// Backpressure: none; load wins over decrement.
module seq_bit_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    // Count register: load a new value or step down toward zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a latched pattern MSB-first, R times, GAP idle cycles apart.
// Latency: first bit on out one cycle after accept; done one cycle after the last bit.
// Backpressure: ready low from accept through the done cycle; start is ignored meanwhile.
module seq_pattern_tx
    import seq_tx_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int REP_W   = 4,
    parameter int GAP     = 2
) (
    input  logic            clk,
    input  logic            reset,
    seq_pattern_tx_if.slave bus
);

    localparam int LEN_W = len_width(MAX_LEN);
    localparam int GAP_W = gap_width(GAP);
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'((GAP > 0) ? GAP - 1 : 0);

    state_t             state;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic [REP_W-1:0]   rep_q;
    logic               ready_q;
    logic               out_q;
    logic               out_valid_q;
    logic               done_q;

    logic [LEN_W-1:0]   len_in_eff;
    logic [REP_W-1:0]   rep_in_m1;

    logic               idx_load;
    logic [LEN_W-1:0]   idx_load_val;
    logic               idx_dec;
    logic [LEN_W-1:0]   idx_cnt;
    logic               idx_zero;

    logic               gap_load;
    logic               gap_dec;
    logic [GAP_W-1:0]   gap_cnt;
    logic               gap_zero;

    // Select bit i of p through a shift so the index width never has to match.
    function automatic logic pick(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] i);
        logic [MAX_LEN-1:0] s;
        s = p >> i;
        return s[0];
    endfunction

    // Oversized lengths clamp to MAX_LEN; a repeat count of 0 means one pass.
    always_comb begin
        len_in_eff = (bus.len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.len;
        rep_in_m1  = (bus.reps == '0) ? '0 : bus.reps - REP_W'(1);
    end

    // Counter controls, kept in step with the FSM transitions below.
    always_comb begin
        idx_load     = 1'b0;
        idx_load_val = '0;
        idx_dec      = 1'b0;
        gap_load     = 1'b0;
        gap_dec      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    idx_load     = 1'b1;
                    idx_load_val = len_in_eff - LEN_W'(1);
                end
            end
            SHIFT: begin
                if (!idx_zero) begin
                    idx_dec = 1'b1;
                end else if (rep_q != '0) begin
                    idx_load     = 1'b1;
                    idx_load_val = len_q - LEN_W'(1);
                    gap_load     = (GAP > 0);
                end
            end
            GAP_WAIT: begin
                gap_dec = !gap_zero;
            end
            default: ;
        endcase
    end

    seq_bit_counter #(.W(LEN_W)) u_idx_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (idx_load),
        .load_val (idx_load_val),
        .dec      (idx_dec),
        .count    (idx_cnt),
        .zero     (idx_zero)
    );

    seq_bit_counter #(.W(GAP_W)) u_gap_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (gap_load),
        .load_val (GAP_INIT),
        .dec      (gap_dec),
        .count    (gap_cnt),
        .zero     (gap_zero)
    );

    // Main FSM; outputs are computed one edge ahead so they come straight from flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pat_q       <= '0;
            len_q       <= '0;
            rep_q       <= '0;
            ready_q     <= RST_READY;
            out_q       <= RST_OUT;
            out_valid_q <= RST_OUT_VALID;
            done_q      <= RST_DONE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        pat_q   <= bus.pattern;
                        len_q   <= len_in_eff;
                        rep_q   <= rep_in_m1;
                        ready_q <= 1'b0;
                        if (len_in_eff == '0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state       <= SHIFT;
                            out_q       <= pick(bus.pattern, len_in_eff - LEN_W'(1));
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (!idx_zero) begin
                        out_q       <= pick(pat_q, idx_cnt - LEN_W'(1));
                        out_valid_q <= 1'b1;
                    end else if (rep_q == '0) begin
                        state       <= DONE;
                        out_q       <= 1'b0;
                        out_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                    end else begin
                        rep_q <= rep_q - REP_W'(1);
                        if (GAP > 0) begin
                            state       <= GAP_WAIT;
                            out_q       <= 1'b0;
                            out_valid_q <= 1'b0;
                        end else begin
                            out_q       <= pick(pat_q, len_q - LEN_W'(1));
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                GAP_WAIT: begin
                    if (gap_zero) begin
                        state       <= SHIFT;
                        out_q       <= pick(pat_q, idx_cnt);
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready     = ready_q;
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: one instance with GAP=2, one with GAP=0.
// Latency: checks every cycle of each job against a hand-written cycle stream.
// Backpressure: covers busy start, held start and mid-job input changes.
module tb_seq_pattern_tx;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    seq_pattern_tx_if #(.MAX_LEN(8), .REP_W(4)) ifa ();
    seq_pattern_tx_if #(.MAX_LEN(8), .REP_W(4)) ifb ();

    seq_pattern_tx #(.MAX_LEN(8), .REP_W(4), .GAP(2)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa.slave)
    );

    seq_pattern_tx #(.MAX_LEN(8), .REP_W(4), .GAP(0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle code -> {ready, out_valid, out, done}.
    // '1'/'0' = valid bit, '_' = gap, 'D' = done pulse, 'R' = idle and ready.
    function automatic logic [3:0] exp_of(input byte ch);
        case (ch)
            "1":     return 4'b0110;
            "0":     return 4'b0100;
            "_":     return 4'b0000;
            "D":     return 4'b0001;
            default: return 4'b1000;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r);
        ifa.pattern = p; ifa.len = l; ifa.reps = r; ifa.start = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        tests++;
        if ({ifa.ready, ifa.out_valid, ifa.out, ifa.done} !== 4'b1000) begin
            fails++;
            $display("FAIL reset_a: got %b expected %b", {ifa.ready, ifa.out_valid, ifa.out, ifa.done}, 4'b1000);
        end
        tests++;
        if ({ifb.ready, ifb.out_valid, ifb.out, ifb.done} !== 4'b1000) begin
            fails++;
            $display("FAIL reset_b: got %b expected %b", {ifb.ready, ifb.out_valid, ifb.out, ifb.done}, 4'b1000);
        end
        reset = 1'b0;
        step();
    endtask

    // Drive one job into instance A and check every following cycle.
    task automatic test_stream_a(input string name, input logic [7:0] p, input logic [3:0] l,
                                 input logic [3:0] r, input string s);
        logic [3:0] obs;
        load_a(p, l, r);
        for (int c = 0; c < s.len(); c++) begin
            step();
            if (c == 0) ifa.start = 1'b0;
            obs = {ifa.ready, ifa.out_valid, ifa.out, ifa.done};
            tests++;
            if (obs !== exp_of(s[c])) begin
                fails++;
                $display("FAIL %s cycle k+%0d: got %b expected %b", name, c + 1, obs, exp_of(s[c]));
            end
        end
    endtask

    task automatic test_no_bubble();
        logic [3:0] obs;
        string s;
        s = "111111DR";
        ifb.pattern = 8'b11; ifb.len = 4'd2; ifb.reps = 4'd3; ifb.start = 1'b1;
        for (int c = 0; c < s.len(); c++) begin
            step();
            if (c == 0) ifb.start = 1'b0;
            obs = {ifb.ready, ifb.out_valid, ifb.out, ifb.done};
            tests++;
            if (obs !== exp_of(s[c])) begin
                fails++;
                $display("FAIL no_bubble cycle k+%0d: got %b expected %b", c + 1, obs, exp_of(s[c]));
            end
        end
    endtask

    task automatic test_max_reps();
        logic [3:0] obs;
        string s;
        s = "111111111111111DRR";
        ifb.pattern = 8'b1; ifb.len = 4'd1; ifb.reps = 4'd15; ifb.start = 1'b1;
        for (int c = 0; c < s.len(); c++) begin
            step();
            if (c == 0) ifb.start = 1'b0;
            obs = {ifb.ready, ifb.out_valid, ifb.out, ifb.done};
            tests++;
            if (obs !== exp_of(s[c])) begin
                fails++;
                $display("FAIL max_reps cycle k+%0d: got %b expected %b", c + 1, obs, exp_of(s[c]));
            end
        end
    endtask

    task automatic test_busy_change();
        logic [3:0] obs;
        string s;
        s = "11000011DRR";
        load_a(8'hC3, 4'd8, 4'd1);
        for (int c = 0; c < s.len(); c++) begin
            step();
            if (c == 0) ifa.start = 1'b0;
            if (c == 2) begin
                ifa.start = 1'b1; ifa.pattern = 8'h00; ifa.len = 4'd1; ifa.reps = 4'd5;
            end
            if (c == 4) ifa.start = 1'b0;
            if (c == 5) ifa.pattern = 8'hFF;
            obs = {ifa.ready, ifa.out_valid, ifa.out, ifa.done};
            tests++;
            if (obs !== exp_of(s[c])) begin
                fails++;
                $display("FAIL busy_change cycle k+%0d: got %b expected %b", c + 1, obs, exp_of(s[c]));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] obs;
        string s;
        s = "110DR110DR";
        load_a(8'b110, 4'd3, 4'd1);
        for (int c = 0; c < s.len(); c++) begin
            step();
            if (c == 5) ifa.start = 1'b0;
            obs = {ifa.ready, ifa.out_valid, ifa.out, ifa.done};
            tests++;
            if (obs !== exp_of(s[c])) begin
                fails++;
                $display("FAIL back_to_back cycle k+%0d: got %b expected %b", c + 1, obs, exp_of(s[c]));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] obs;
        load_a(8'hFF, 4'd8, 4'd1);
        for (int c = 0; c < 3; c++) begin
            step();
            if (c == 0) ifa.start = 1'b0;
            obs = {ifa.ready, ifa.out_valid, ifa.out, ifa.done};
            tests++;
            if (obs !== 4'b0110) begin
                fails++;
                $display("FAIL reset_mid bit %0d: got %b expected %b", c + 1, obs, 4'b0110);
            end
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            obs = {ifa.ready, ifa.out_valid, ifa.out, ifa.done};
            tests++;
            if (obs !== 4'b1000) begin
                fails++;
                $display("FAIL reset_mid after_reset %0d: got %b expected %b", c, obs, 4'b1000);
            end
            step();
        end
        #0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        ifa.start = 1'b0; ifa.pattern = '0; ifa.len = '0; ifa.reps = '0;
        ifb.start = 1'b0; ifb.pattern = '0; ifb.len = '0; ifb.reps = '0;

        test_reset();
        test_stream_a("basic",      8'h1F,        4'd5,  4'd1, "11111DR");
        test_stream_a("order_gap",  8'b0000_0101, 4'd3,  4'd2, "101__101DR");
        test_stream_a("len_zero",   8'hFF,        4'd0,  4'd3, "DRR");
        test_stream_a("reps_zero",  8'b10,        4'd2,  4'd0, "10DRR");
        test_stream_a("len_clamp",  8'hA5,        4'd12, 4'd1, "10100101DR");
        test_stream_a("gap_3reps",  8'b1,         4'd1,  4'd3, "1__1__1DR");
        test_no_bubble();
        test_max_reps();
        test_busy_change();
        test_back_to_back();
        test_reset_mid();
        test_stream_a("after_reset", 8'b01,       4'd2,  4'd1, "01DR");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard stop in case something above stops advancing.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget, got no finish expected finish");
        $fatal(1);
    end

endmodule
